crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
Parametrised, word-streaming CRC engine. It is the successor to the single-bit serial LFSR stage.
- Accepts DATA_W-bit words over a valid/ready handshake and shifts them serially, one bit per clock, through a runtime-configurable CRC of width 1..MAX_BITS.
- Adds input/output reflection, final XOR and a result handshake.
- Sits between the byte-stream front end and the result/readback logic.

Parameters:
MAX_BITS, 64, maximum CRC width supported
DATA_W, 8, input word width in bits (>=1)
BW_W, 7, width of bitwidth port, equals $clog2(MAX_BITS+1)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  pulse: latch config, load init_value
bitwidth  input  BW_W  CRC width W, legal 1..MAX_BITS
taps  input  MAX_BITS  polynomial without implicit x^W term
init_value  input  MAX_BITS  initial register value
xor_out  input  MAX_BITS  final XOR mask
reflect_in  input  1  1 = LSB of each word shifted first
reflect_out  input  1  1 = bit-reverse result over W bits before XOR
in_valid  input  1  word valid
in_ready  output  1  engine can accept a word
in_data  input  DATA_W  data word
in_last  input  1  word is last of message
out_valid  output  1  result valid
out_ready  input  1  result consumed
out_crc  output  MAX_BITS  final CRC, bits >= W are zero
cfg_err  output  1  one-cycle pulse on start with illegal bitwidth

Behaviour:
- Reset (async assert, sync deassert in the reset tree):
  - state=IDLE, crc=0, latched config=0.
  - in_ready=0, out_valid=0, out_crc=0, cfg_err=0.
- States: IDLE, READY, SHIFT, FINAL, DONE.
- start handling:
  - start in IDLE or READY with 1<=bitwidth<=MAX_BITS: latch bitwidth, taps, xor_out, reflect_*, init_value; crc<=init_value&mask; next state READY.
  - Illegal bitwidth: cfg_err=1 for one cycle; state and config unchanged.
  - start is ignored in SHIFT, FINAL and DONE.
- mask = (1<<W)-1. All crc updates are ANDed with mask.
- READY state:
  - in_ready=1.
  - Handshake (in_valid&in_ready): latch in_data into a shift register, latch in_last, bit counter=0, next state SHIFT.
  - start has priority over a simultaneous handshake; the word is not accepted.
- SHIFT state, one bit per cycle for exactly DATA_W cycles; in_ready=0.
  - d = in_data[DATA_W-1-k] if reflect_in=0, else in_data[k].
  - fb = crc[W-1]^d.
  - crc <= ((crc<<1) ^ (fb ? taps : 0)) & mask.
  - After bit DATA_W-1: go to FINAL if last, else READY.
- Word cost: 1 accept cycle + DATA_W shift cycles.
- FINAL (1 cycle): out_crc <= ((reflect_out ? rev_W(crc) : crc) ^ xor_out) & mask. rev_W reverses bits [W-1:0].
- DONE state:
  - out_valid=1; out_crc held stable until out_ready.
  - On out_valid&out_ready: out_valid<=0, crc<=latched init&mask, next state READY. Config is retained.
- out_crc keeps its last value after it is consumed; it changes only at FINAL or reset.
- W=1 is legal (parity-style). W=MAX_BITS must not overflow: shift discards bit MAX_BITS-1.
- rst_n asserted mid-message: immediate return to reset values. Any partially shifted word is lost.

Decomposition:
- Shared package crc_pkg:
  - state enum (IDLE, READY, SHIFT, FINAL, DONE).
  - Mask and bit-reverse functions parametrised by MAX_BITS.
  - Standard polynomial constants (CRC8 0x07, CRC16_CCITT 0x1021, CRC32 0x04C11DB7).
- One natural sub-module: crc_bit_step. Combinational one-bit update (crc, d, taps, mask -> next crc), reusable by a future parallel unrolled variant.

Test Plan:
- CRC-8: W=8, taps=0x07, init=0, xor=0, no reflect; "123456789" (9 words, last on 9th) -> out_crc=0xF4.
  - out_valid rises 9*(1+8)+1 cycles after the first accept.
- CRC-16/CCITT-FALSE: W=16, taps=0x1021, init=0xFFFF, xor=0; same string -> 0x29B1. Hold out_ready=0 for 5 cycles -> out_crc/out_valid stable.
- CRC-32: W=32, taps=0x04C11DB7, init=xor=0xFFFFFFFF, reflect_in=reflect_out=1; same string -> 0xCBF43926.
  - Then a back-to-back second message without start -> identical result (init reloaded).
- Config errors and start priority:
  - start with bitwidth=0, then with bitwidth=65 -> cfg_err pulse each time, state stays IDLE, in_ready=0.
  - start during SHIFT -> ignored, result unchanged.
  - start colliding with in_valid in READY -> word not accepted.
- Reset and backpressure:
  - rst_n low mid-SHIFT of word 4 -> all outputs 0 asynchronously. After release, in_ready=0 until start.
  - in_valid held during SHIFT -> no extra word taken (accept count = in_last count check).

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and helpers for the word-streaming CRC engine.
// Latency: none, the helpers are purely combinational.
// Backpressure: not applicable, holds no state.
package crc_pkg;

    // Widest CRC the helpers handle; engine instances must not exceed it.
    localparam int CRC_MAX_BITS = 64;

    // Common polynomials, written without the implicit x^W term.
    localparam logic [CRC_MAX_BITS-1:0] CRC8_POLY        = 64'h0000_0000_0000_0007;
    localparam logic [CRC_MAX_BITS-1:0] CRC16_CCITT_POLY = 64'h0000_0000_0000_1021;
    localparam logic [CRC_MAX_BITS-1:0] CRC32_POLY       = 64'h0000_0000_04C1_1DB7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } crc_state_t;

    // Ones in bits [w-1:0]; built bitwise so w == CRC_MAX_BITS cannot overflow.
    function automatic logic [CRC_MAX_BITS-1:0] crc_mask(input int w);
        logic [CRC_MAX_BITS-1:0] m;
        for (int i = 0; i < CRC_MAX_BITS; i++) begin
            m[i] = (i < w);
        end
        return m;
    endfunction

    // Reverse bits [w-1:0]: reverse the full word, then slide the window down.
    function automatic logic [CRC_MAX_BITS-1:0] crc_rev(input logic [CRC_MAX_BITS-1:0] v,
                                                        input int w);
        logic [CRC_MAX_BITS-1:0] r;
        for (int i = 0; i < CRC_MAX_BITS; i++) begin
            r[i] = v[CRC_MAX_BITS-1-i];
        end
        return (r >> (CRC_MAX_BITS - w)) & crc_mask(w);
    endfunction

endpackage

// File: rtl/crc_bit_step.sv
// One-bit CRC register update: shift in one data bit through the polynomial.
// Latency: combinational.
// Backpressure: none, caller decides when to apply the result.
module crc_bit_step #(
    parameter int MAX_BITS = 64
)(
    input  logic [MAX_BITS-1:0] i_crc,
    input  logic                i_d,
    input  logic [MAX_BITS-1:0] i_taps,
    input  logic [MAX_BITS-1:0] i_mask,
    output logic [MAX_BITS-1:0] o_crc
);
    logic w_msb;
    logic w_fb;

    // The top active bit is the one bit of the mask not covered by mask>>1.
    assign w_msb = |(i_crc & i_mask & ~(i_mask >> 1));
    assign w_fb  = w_msb ^ i_d;
    // Shifting in MAX_BITS width drops bit MAX_BITS-1 when W is at maximum.
    assign o_crc = ((i_crc << 1) ^ (w_fb ? i_taps : '0)) & i_mask;

endmodule

// File: rtl/crc_stream_engine.sv
// Word-streaming CRC: accepts DATA_W-bit words and shifts them one bit per clock.
// Latency: 1 accept + DATA_W shift cycles per word, plus 1 finalize cycle after the last word.
// Backpressure: in_ready only in READY; result held in DONE until out_ready.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int DATA_W   = 8,
    parameter int BW_W     = 7
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BW_W-1:0]     bitwidth,
    input  logic [MAX_BITS-1:0] taps,
    input  logic [MAX_BITS-1:0] init_value,
    input  logic [MAX_BITS-1:0] xor_out,
    input  logic                reflect_in,
    input  logic                reflect_out,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MAX_BITS-1:0] out_crc,
    output logic                cfg_err
);
    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    crc_state_t            r_state;
    crc_state_t            w_state_nxt;
    logic [BW_W-1:0]       r_bw;
    logic [MAX_BITS-1:0]   r_taps;
    logic [MAX_BITS-1:0]   r_init;
    logic [MAX_BITS-1:0]   r_xor;
    logic [MAX_BITS-1:0]   r_crc;
    logic [MAX_BITS-1:0]   r_out_crc;
    logic                  r_refin;
    logic                  r_refout;
    logic                  r_last;
    logic                  r_cfg_err;
    logic [DATA_W-1:0]     r_shreg;
    logic [CNT_W-1:0]      r_cnt;

    logic                    w_idle_or_ready;
    logic                    w_bw_legal;
    logic                    w_start_ok;
    logic                    w_start_bad;
    logic                    w_accept;
    logic                    w_last_bit;
    logic                    w_d;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic [CRC_MAX_BITS-1:0] w_mask_full;
    logic [CRC_MAX_BITS-1:0] w_new_mask_full;
    logic [CRC_MAX_BITS-1:0] w_rev_full;
    logic [MAX_BITS-1:0]     w_mask;
    logic [MAX_BITS-1:0]     w_new_mask;
    logic [MAX_BITS-1:0]     w_crc_step;
    logic [MAX_BITS-1:0]     w_final;

    assign w_idle_or_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
    assign w_bw_legal      = (bitwidth != '0) && (bitwidth <= BW_W'(MAX_BITS));
    assign w_start_ok      = start && w_idle_or_ready && w_bw_legal;
    assign w_start_bad     = start && w_idle_or_ready && !w_bw_legal;
    // start outranks a simultaneous word: the word stays with the sender.
    assign w_accept        = in_valid && (r_state == ST_READY) && !start;
    assign w_last_bit      = (r_cnt == LAST_BIT);

    assign w_mask_full     = crc_mask(int'(r_bw));
    assign w_new_mask_full = crc_mask(int'(bitwidth));
    assign w_mask          = w_mask_full[MAX_BITS-1:0];
    assign w_new_mask      = w_new_mask_full[MAX_BITS-1:0];

    // Shift register always presents the next bit at a fixed end.
    assign w_d = r_refin ? r_shreg[0] : r_shreg[DATA_W-1];

    assign w_rev_full = crc_rev(CRC_MAX_BITS'(r_crc), int'(r_bw));
    assign w_final    = ((r_refout ? w_rev_full[MAX_BITS-1:0] : r_crc) ^ r_xor) & w_mask;

    crc_bit_step #(
        .MAX_BITS (MAX_BITS)
    ) u_bit_step (
        .i_crc  (r_crc),
        .i_d    (w_d),
        .i_taps (r_taps),
        .i_mask (w_mask),
        .o_crc  (w_crc_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_READY;
            ST_READY: begin
                if (w_start_ok)    w_state_nxt = ST_READY;
                else if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (w_last_bit) w_state_nxt = r_last ? ST_FINAL : ST_READY;
            ST_FINAL: w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_READY: w_in_ready  = 1'b1;
            ST_DONE:  w_out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Config latch, CRC register, word shifter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bw      <= '0;
            r_taps    <= '0;
            r_init    <= '0;
            r_xor     <= '0;
            r_refin   <= 1'b0;
            r_refout  <= 1'b0;
            r_crc     <= '0;
            r_shreg   <= '0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            r_out_crc <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_bw     <= bitwidth;
                r_taps   <= taps;
                r_init   <= init_value;
                r_xor    <= xor_out;
                r_refin  <= reflect_in;
                r_refout <= reflect_out;
                r_crc    <= init_value & w_new_mask;
            end else begin
                case (r_state)
                    ST_READY: if (w_accept) begin
                        r_shreg <= in_data;
                        r_last  <= in_last;
                        r_cnt   <= '0;
                    end
                    ST_SHIFT: begin
                        r_crc   <= w_crc_step;
                        r_shreg <= r_refin ? (r_shreg >> 1) : (r_shreg << 1);
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    ST_FINAL: r_out_crc <= w_final;
                    ST_DONE:  if (out_ready) r_crc <= r_init & w_mask;
                    default:  ;
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_crc   = r_out_crc;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: standard CRC vectors plus randomized configs
// checked against a polynomial long-division model.
module tb_crc_stream_engine;
    localparam int MAX_BITS = 64;
    localparam int DATA_W   = 8;
    localparam int BW_W     = 7;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [BW_W-1:0]     bitwidth;
    logic [MAX_BITS-1:0] taps;
    logic [MAX_BITS-1:0] init_value;
    logic [MAX_BITS-1:0] xor_out;
    logic                reflect_in;
    logic                reflect_out;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [MAX_BITS-1:0] out_crc;
    logic                cfg_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int acc_cnt = 0;
    int last_cnt = 0;
    logic [7:0] g_msg[$];

    crc_stream_engine #(.MAX_BITS(MAX_BITS), .DATA_W(DATA_W), .BW_W(BW_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bitwidth(bitwidth), .taps(taps),
        .init_value(init_value), .xor_out(xor_out), .reflect_in(reflect_in),
        .reflect_out(reflect_out), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_crc(out_crc), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Cycle counter and accepted-word monitor.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid && in_ready && !start) begin
            acc_cnt++;
            if (in_last) last_cnt++;
        end
    end

    // CRC as remainder of (init * x^N + M(x) * x^W) mod (x^W + taps).
    function automatic logic [63:0] model_crc(input int w, input logic [63:0] tp,
                                              input logic [63:0] iv, input logic [63:0] xo,
                                              input bit ri, input bit ro);
        bit dv [0:255];
        int n;
        logic [63:0] rem;
        logic [63:0] res;
        n = g_msg.size() * 8;
        for (int p = 0; p < 256; p++) dv[p] = 1'b0;
        for (int j = 0; j < n; j++) begin
            logic [7:0] b;
            b = g_msg[j / 8];
            dv[n + w - 1 - j] = ri ? b[j % 8] : b[7 - (j % 8)];
        end
        for (int i = 0; i < w; i++) dv[n + i] ^= iv[i];
        for (int p = n + w - 1; p >= w; p--) begin
            if (dv[p]) begin
                dv[p] = 1'b0;
                for (int i = 0; i < w; i++) dv[p - w + i] ^= tp[i];
            end
        end
        rem = '0;
        for (int i = 0; i < w; i++) rem[i] = dv[i];
        res = '0;
        for (int i = 0; i < w; i++) res[i] = (ro ? rem[w - 1 - i] : rem[i]) ^ xo[i];
        return res;
    endfunction

    task automatic load_check_string();
        g_msg.delete();
        for (int i = 1; i <= 9; i++) g_msg.push_back(8'h30 + 8'(i));
    endtask

    task automatic start_cfg(input int w, input logic [63:0] tp, input logic [63:0] iv,
                             input logic [63:0] xo, input bit ri, input bit ro);
        bitwidth = BW_W'(w); taps = tp; init_value = iv; xor_out = xo;
        reflect_in = ri; reflect_out = ro; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit last, input bit first, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (in_ready) begin
                if (first) t0 = cyc;
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    // Streams g_msg; optionally pulses start while the word at start_at is shifting.
    task automatic run_msg(input int start_at, output logic [63:0] res, output int lat);
        bit ok;
        int a0, l0;
        a0 = acc_cnt; l0 = last_cnt;
        res = '0; lat = -1;
        for (int i = 0; i < g_msg.size(); i++) begin
            send_word(g_msg[i], i == g_msg.size() - 1, i == 0, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL accept_timeout word=%0d in_ready=%b required=1", i, in_ready);
                break;
            end
            if (i == start_at) begin
                bitwidth = 7'd16; taps = 64'h1021; init_value = 64'hFFFF; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int n = 0; n < 300 && !out_valid; n++) @(negedge clk);
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL result_timeout out_valid=%b required=1", out_valid);
        end else begin
            res = out_crc;
            lat = cyc - t0;
        end
        checks++;
        if (acc_cnt - a0 !== g_msg.size()) begin
            errors++;
            $display("FAIL accept_count got=%0d required=%0d", acc_cnt - a0, g_msg.size());
        end
        checks++;
        if (last_cnt - l0 !== 1) begin
            errors++;
            $display("FAIL last_count got=%0d required=1", last_cnt - l0);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++; if (out_crc !== '0) begin errors++; $display("FAIL reset_out_crc got=%h required=0", out_crc); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b required=0", cfg_err); end
    endtask

    task automatic test_cfg_err();
        int bad_w[2];
        bad_w[0] = 0; bad_w[1] = 65;
        for (int k = 0; k < 2; k++) begin
            start_cfg(bad_w[k], 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse w=%0d got=%b required=1", bad_w[k], cfg_err); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_err_state w=%0d in_ready=%b required=0", bad_w[k], in_ready); end
            @(negedge clk);
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width w=%0d got=%b required=0", bad_w[k], cfg_err); end
        end
    endtask

    task automatic test_crc8();
        logic [63:0] r; int lat;
        load_check_string();
        start_cfg(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
        run_msg(-1, r, lat);
        checks++; if (r !== 64'hF4) begin errors++; $display("FAIL crc8_value got=%h required=%h", r, 64'hF4); end
        checks++; if (lat !== 9 * (1 + DATA_W) + 1) begin errors++; $display("FAIL crc8_latency got=%0d required=%0d", lat, 9 * (1 + DATA_W) + 1); end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL crc8_consumed out_valid=%b required=0", out_valid); end
        checks++; if (out_crc !== 64'hF4) begin errors++; $display("FAIL crc8_retained got=%h required=%h", out_crc, 64'hF4); end
    endtask

    task automatic test_crc16_hold();
        logic [63:0] r; int lat;
        load_check_string();
        start_cfg(16, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0);
        run_msg(-1, r, lat);
        checks++; if (r !== 64'h29B1) begin errors++; $display("FAIL crc16_value got=%h required=%h", r, 64'h29B1); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_crc !== 64'h29B1) begin
                errors++;
                $display("FAIL crc16_hold cycle=%0d valid=%b crc=%h required valid=1 crc=%h", k, out_valid, out_crc, 64'h29B1);
            end
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; int lat;
        load_check_string();
        start_cfg(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1);
        run_msg(-1, r, lat);
        checks++; if (r !== 64'hCBF43926) begin errors++; $display("FAIL crc32_value got=%h required=%h", r, 64'hCBF43926); end
        consume();
        run_msg(-1, r, lat);
        checks++; if (r !== 64'hCBF43926) begin errors++; $display("FAIL crc32_second got=%h required=%h", r, 64'hCBF43926); end
        consume();
    endtask

    task automatic test_start_in_shift();
        logic [63:0] r; int lat;
        load_check_string();
        start_cfg(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
        run_msg(2, r, lat);
        checks++; if (r !== 64'hF4) begin errors++; $display("FAIL start_in_shift got=%h required=%h", r, 64'hF4); end
        consume();
    endtask

    task automatic test_start_collide();
        logic [63:0] r; int lat;
        bitwidth = 7'd8; taps = 64'h07; init_value = '0; xor_out = '0;
        reflect_in = 1'b0; reflect_out = 1'b0;
        start = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL collide_not_taken in_ready=%b required=1", in_ready); end
        load_check_string();
        run_msg(-1, r, lat);
        checks++; if (r !== 64'hF4) begin errors++; $display("FAIL collide_result got=%h required=%h", r, 64'hF4); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        load_check_string();
        start_cfg(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_word(g_msg[i], 1'b0, i == 0, ok);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_crc !== '0) begin errors++; $display("FAIL rstmid_out_crc got=%h required=0", out_crc); end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags ready=%b valid=%b err=%b required all 0", in_ready, out_valid, cfg_err);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_idle cycle=%0d in_ready=%b required=0", k, in_ready); end
        end
        start_cfg(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_restart in_ready=%b required=1", in_ready); end
    endtask

    task automatic test_random();
        logic [63:0] r, exp, tp, iv, xo;
        int lat, w, len;
        bit ri, ro;
        for (int it = 0; it < 10; it++) begin
            w  = (it == 0) ? 1 : (it == 1) ? 64 : int'($urandom_range(1, 64));
            tp = {$urandom, $urandom}; iv = {$urandom, $urandom}; xo = {$urandom, $urandom};
            ri = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 4));
            g_msg.delete();
            for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom));
            exp = model_crc(w, tp, iv, xo, ri, ro);
            start_cfg(w, tp, iv, xo, ri, ro);
            run_msg(-1, r, lat);
            checks++;
            if (r !== exp) begin
                errors++;
                $display("FAIL random_crc it=%0d w=%0d got=%h required=%h", it, w, r, exp);
            end
            consume();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bitwidth = '0; taps = '0; init_value = '0;
        xor_out = '0; reflect_in = 1'b0; reflect_out = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_cfg_err();
        test_crc8();
        test_crc16_hold();
        test_back_to_back();
        test_start_in_shift();
        test_start_collide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
